clk_div_ctrl: RTL and testbench
===============================

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the half-period count.
REQ-002 SHALL have parameter DEF_HALF, default 1: half-period loaded at reset, in clk_in cycles, range 1..2^CNT_W-1.
REQ-003 SHALL have port clk_in  input  1: clock; all logic on posedge.
REQ-004 SHALL have port arst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1: run request; 1 = generate clock, 0 = stop at the next safe boundary.
REQ-006 SHALL have port cfg_valid  input  1: requester offers a new half-period.
REQ-007 SHALL have port cfg_half  input  CNT_W: requested half-period in clk_in cycles; division factor = 2*cfg_half.
REQ-008 SHALL have port cfg_ready  output  1: high when no config is pending.
REQ-009 SHALL have port clk_out  output  1: divided clock, registered.
REQ-010 SHALL have port active  output  1: high in RUN and STOP states.
REQ-011 SHALL have port cur_half  output  CNT_W: half-period currently in effect.
REQ-012 SHALL have port cfg_err  output  1: one-cycle pulse on a rejected config (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE, RUN, STOP.
REQ-014 IDLE: clk_out=0, counter=0; when en=1 is sampled, next state RUN, clk_out<=1, counter<=0 (first rising edge one cycle after en is sampled).
REQ-015 RUN: counter increments each cycle; at counter==cur_half-1, toggle clk_out and clear counter; each phase lasts exactly cur_half cycles.
REQ-016 Falling boundary = RUN/STOP cycle with counter==cur_half-1 and clk_out==1; it is the only point where cur_half or run state may change.
REQ-017 Handshake: transfer when cfg_valid&&cfg_ready; cfg_half is captured into the pending register; cfg_ready<=0 until the pending value is applied.
REQ-018 In RUN/STOP, the pending value is applied to cur_half at the next falling boundary; the following low phase uses the new value; cfg_ready returns to 1 in the cycle after application.
REQ-019 In IDLE, an accepted config is applied on the next clock edge; cfg_ready is low for exactly one cycle.
REQ-020 en=0 sampled in RUN moves to STOP; STOP finishes the current high phase and enters IDLE at the falling boundary; clk_out ends low with no phase shorter than cur_half.
REQ-021 en=1 sampled in STOP returns to RUN with no disturbance to clk_out.
REQ-022 When a pending config and a stop meet at the same boundary, both take effect: cur_half updates and the state becomes IDLE.
REQ-023 When the counter is at cur_half-1 and a transfer occurs in the same cycle, the new value is not applied until the next falling boundary.
REQ-024 cur_half=1 SHALL give clk_out toggling every cycle (divide by 2).

Reset
REQ-025 On asserting arst_n=0, outputs SHALL take these values immediately: clk_out=0, active=0, cfg_ready=1, cfg_err=0, cur_half=DEF_HALF; state IDLE; counter=0; any pending config is discarded.
REQ-026 Reset in mid-operation SHALL truncate the current phase without a glitch beyond the async clear.

Configuration
REQ-027 Macro CLK_DIV_CTRL_CHK_EN defined: a transfer with cfg_half==0 is accepted, not applied, and pulses cfg_err for one cycle; cfg_ready stays 1.
REQ-028 Macro undefined: cfg_half==0 is clamped to 1; cfg_err is tied to 0.

Structure
REQ-029 Package clk_div_pkg SHALL hold the state enum (IDLE/RUN/STOP) and the default CNT_W/DEF_HALF constants.
REQ-030 SHALL instantiate one sub-module, clk_div_prog: a loadable counter plus clk_out toggle with inputs run, half, load; the FSM and handshake stay in clk_div_ctrl.

Verification
REQ-031 Reset, then en=1 with DEF_HALF=1 -> clk_out toggles every cycle from one cycle after en; active=1.
REQ-032 Running at half=3, transfer cfg_half=5 mid-high-phase -> high phase still lasts 3 cycles, then the low phase lasts 5 cycles; cfg_ready is low until that boundary.
REQ-033 Running at half=4, drop en two cycles into the high phase -> high phase completes 4 cycles, clk_out=0, state IDLE, active=0.
REQ-034 Drop en and make a pending cfg_half=2 coincide at the same boundary -> IDLE with cur_half=2; a restart shows 2-cycle phases.
REQ-035 With CLK_DIV_CTRL_CHK_EN, send cfg_half=0 -> cfg_err pulses for 1 cycle and cur_half is unchanged; without the macro -> cur_half=1.
REQ-036 Assert arst_n mid-low-phase with a config pending -> clk_out=0 and cur_half=DEF_HALF immediately; the pending config is not applied after release.

Source files
------------

// File: rtl/clk_div_pkg.sv
// ============================================================================
// Module  : clk_div_pkg
// Brief   : Shared state encoding and default sizing for the clock divider.
// Revision: 1.0
// ============================================================================
`default_nettype none

package clk_div_pkg;

  localparam int unsigned c_def_cnt_w = 8;
  localparam int unsigned c_def_half  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/clk_div_prog.sv
// ============================================================================
// Module  : clk_div_prog
// Brief   : Loadable half-period counter driving the registered divided clock.
// Revision: 1.0
// ============================================================================
`default_nettype none

module clk_div_prog #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             arst_n,
  input  logic             run,
  input  logic             load,
  input  logic [CNT_W-1:0] half,
  output logic             clk_out,
  output logic             cnt_end
);

  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_clk;

  assign cnt_end = (r_cnt == (half - c_one));
  assign clk_out = r_clk;

  // load starts a fresh high phase; with neither run nor load the output parks low
  always_ff @(posedge clk_in or negedge arst_n) begin
    if (!arst_n) begin
      r_cnt <= '0;
      r_clk <= 1'b0;
    end else if (load) begin
      r_cnt <= '0;
      r_clk <= 1'b1;
    end else if (run) begin
      if (cnt_end) begin
        r_cnt <= '0;
        r_clk <= ~r_clk;
      end else begin
        r_cnt <= r_cnt + c_one;
      end
    end else begin
      r_cnt <= '0;
      r_clk <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/clk_div_ctrl.sv
// ============================================================================
// Module  : clk_div_ctrl
// Brief   : Run/stop FSM and half-period handshake around clk_div_prog.
//           Define CLK_DIV_CTRL_CHK_EN to reject cfg_half==0 with a cfg_err pulse.
// Revision: 1.0
// ============================================================================
`default_nettype none

module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W    = c_def_cnt_w,
  parameter int unsigned DEF_HALF = c_def_half
) (
  input  logic             clk_in,
  input  logic             arst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             active,
  output logic [CNT_W-1:0] cur_half,
  output logic             cfg_err
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_pend;
  logic [CNT_W-1:0] r_pend_half;
  logic [CNT_W-1:0] r_cur_half;
  logic             w_xfer;
  logic             w_run;
  logic             w_load;
  logic             w_fall;
  logic             w_apply;
  logic             w_cnt_end;
  logic             w_clk;

  assign w_xfer  = cfg_valid && !r_pend;
  assign w_run   = (r_state != IDLE);
  assign w_load  = (r_state == IDLE) && en;
  assign w_fall  = w_run && w_cnt_end && w_clk;
  // cur_half only moves while idle or at the falling boundary
  assign w_apply = r_pend && ((r_state == IDLE) || w_fall);

  assign cfg_ready = !r_pend;
  assign clk_out   = w_clk;
  assign active    = w_run;
  assign cur_half  = r_cur_half;

  always_ff @(posedge clk_in or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // RUN and STOP only differ by en; the exit decision is taken at the falling boundary
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (en) w_state_nxt = RUN;
      RUN, STOP: begin
        if (w_fall) w_state_nxt = en ? RUN : IDLE;
        else        w_state_nxt = en ? RUN : STOP;
      end
      default:   w_state_nxt = IDLE;
    endcase
  end

`ifdef CLK_DIV_CTRL_CHK_EN
  logic r_cfg_err;
  assign cfg_err = r_cfg_err;
`else
  assign cfg_err = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge arst_n) begin
    if (!arst_n) begin
      r_pend      <= 1'b0;
      r_pend_half <= '0;
      r_cur_half  <= CNT_W'(DEF_HALF);
`ifdef CLK_DIV_CTRL_CHK_EN
      r_cfg_err   <= 1'b0;
`endif
    end else begin
`ifdef CLK_DIV_CTRL_CHK_EN
      r_cfg_err <= 1'b0;
`endif
      if (w_apply) begin
        r_cur_half <= r_pend_half;
        r_pend     <= 1'b0;
      end
      if (w_xfer) begin
`ifdef CLK_DIV_CTRL_CHK_EN
        if (cfg_half == '0) begin
          r_cfg_err <= 1'b1;
        end else begin
          r_pend      <= 1'b1;
          r_pend_half <= cfg_half;
        end
`else
        r_pend      <= 1'b1;
        r_pend_half <= (cfg_half == '0) ? CNT_W'(1) : cfg_half;
`endif
      end
    end
  end

  clk_div_prog #(
    .CNT_W (CNT_W)
  ) u_prog (
    .clk_in  (clk_in),
    .arst_n  (arst_n),
    .run     (w_run),
    .load    (w_load),
    .half    (r_cur_half),
    .clk_out (w_clk),
    .cnt_end (w_cnt_end)
  );

endmodule

`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
// ============================================================================
// Module  : tb_clk_div_ctrl
// Brief   : Directed bench for clk_div_ctrl with a phase-countdown reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_clk_div_ctrl;

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned DEF_HALF = 1;

  logic             clk_in = 1'b0;
  logic             arst_n = 1'b1;
  logic             en = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_half = '0;
  logic             cfg_ready;
  logic             clk_out;
  logic             active;
  logic [CNT_W-1:0] cur_half;
  logic             cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  clk_div_ctrl #(
    .CNT_W    (CNT_W),
    .DEF_HALF (DEF_HALF)
  ) dut (
    .clk_in    (clk_in),
    .arst_n    (arst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_half  (cfg_half),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .active    (active),
    .cur_half  (cur_half),
    .cfg_err   (cfg_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference: the output is a sequence of phases of m_half cycles; en is only
  // consulted at the end of a high phase, and config moves only when idle or there.
  logic             m_lvl, m_on, m_pend_v, m_err, m_xfer;
  int               m_left;
  logic [CNT_W-1:0] m_half, m_pend, m_v;

  initial begin
    forever begin
      @(posedge clk_in or negedge arst_n);
      if (!arst_n) begin
        m_lvl = 1'b0; m_on = 1'b0; m_pend_v = 1'b0; m_err = 1'b0;
        m_left = 0; m_half = CNT_W'(DEF_HALF); m_pend = '0;
      end else begin
        m_xfer = cfg_valid && !m_pend_v;
        m_v    = cfg_half;
        m_err  = 1'b0;
        if (!m_on) begin
          if (m_pend_v) begin m_half = m_pend; m_pend_v = 1'b0; end
          if (en) begin m_on = 1'b1; m_lvl = 1'b1; m_left = int'(m_half); end
        end else if (m_left > 1) begin
          m_left--;
        end else if (m_lvl) begin
          if (m_pend_v) begin m_half = m_pend; m_pend_v = 1'b0; end
          m_lvl  = 1'b0;
          m_left = int'(m_half);
          if (!en) m_on = 1'b0;
        end else begin
          m_lvl  = 1'b1;
          m_left = int'(m_half);
        end
        if (m_xfer) begin
`ifdef CLK_DIV_CTRL_CHK_EN
          if (m_v == 0) m_err = 1'b1;
          else begin m_pend = m_v; m_pend_v = 1'b1; end
`else
          m_pend   = (m_v == 0) ? CNT_W'(1) : m_v;
          m_pend_v = 1'b1;
`endif
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_in);
      chk("model_clk_out",   32'(clk_out),   32'(m_lvl));
      chk("model_active",    32'(active),    32'(m_on));
      chk("model_cur_half",  32'(cur_half),  32'(m_half));
      chk("model_cfg_ready", 32'(cfg_ready), 32'(!m_pend_v));
      chk("model_cfg_err",   32'(cfg_err),   32'(m_err));
    end
  end

  task automatic run_len(output int n);
    logic lvl;
    lvl = clk_out;
    n = 0;
    while (clk_out === lvl && n < 64) begin
      n++;
      @(negedge clk_in);
    end
  endtask

  task automatic wait_clk(input logic lvl, input string nm);
    int k;
    k = 0;
    @(negedge clk_in);
    while (clk_out !== lvl && k < 64) begin
      k++;
      @(negedge clk_in);
    end
    chk(nm, 32'(clk_out), 32'(lvl));
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (active !== 1'b0 && k < 64) begin
      k++;
      @(negedge clk_in);
    end
    chk(nm, 32'(active), 32'd0);
  endtask

  task automatic send_cfg(input logic [CNT_W-1:0] v);
    cfg_valid = 1'b1;
    cfg_half  = v;
    @(negedge clk_in);
    cfg_valid = 1'b0;
  endtask

  initial begin
    int n;
    logic [3:0] hist;
    #1 arst_n = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("rst_clk_out",   32'(clk_out),   32'd0);
    chk("rst_active",    32'(active),    32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_cfg_err",   32'(cfg_err),   32'd0);
    chk("rst_cur_half",  32'(cur_half),  32'd1);
    arst_n = 1'b1;
    @(negedge clk_in);

    // divide by 2 from one cycle after en
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      hist[3-i] = clk_out;
    end
    chk("div2_pattern", 32'(hist), 32'hA);
    chk("div2_active",  32'(active), 32'd1);
    en = 1'b0;
    wait_idle("div2_stop");

    // idle config: ready low one cycle, then applied
    send_cfg(8'd3);
    chk("idle_cfg_ready_low", 32'(cfg_ready), 32'd0);
    @(negedge clk_in);
    chk("idle_cfg_ready_back", 32'(cfg_ready), 32'd1);
    chk("idle_cfg_half3",      32'(cur_half),  32'd3);

    // change 3 -> 5 in the middle of a high phase
    en = 1'b1;
    repeat (2) @(negedge clk_in);
    send_cfg(8'd5);
    chk("mid_high_still_high", 32'(clk_out),   32'd1);
    chk("mid_high_ready_low",  32'(cfg_ready), 32'd0);
    @(negedge clk_in);
    chk("boundary_ready", 32'(cfg_ready), 32'd1);
    chk("boundary_half5", 32'(cur_half),  32'd5);
    run_len(n);
    chk("low_len5", 32'(n), 32'd5);
    run_len(n);
    chk("high_len5", 32'(n), 32'd5);

    // half=4, then stop two cycles into a high phase
    send_cfg(8'd4);
    wait_clk(1'b1, "wait_high_h5");
    wait_clk(1'b0, "wait_low_h4");
    chk("half4_applied", 32'(cur_half), 32'd4);
    run_len(n);
    chk("low_len4", 32'(n), 32'd4);
    @(negedge clk_in);
    en = 1'b0;
    run_len(n);
    chk("stop_high_len4", 32'(n + 1), 32'd4);
    chk("stop_clk_low",   32'(clk_out), 32'd0);
    chk("stop_inactive",  32'(active),  32'd0);

    // stop and pending config meet at one boundary
    en = 1'b1;
    @(negedge clk_in);
    cfg_valid = 1'b1;
    cfg_half  = 8'd2;
    en        = 1'b0;
    @(negedge clk_in);
    cfg_valid = 1'b0;
    wait_idle("coinc_idle");
    chk("coinc_half2", 32'(cur_half),  32'd2);
    chk("coinc_clk",   32'(clk_out),   32'd0);
    chk("coinc_ready", 32'(cfg_ready), 32'd1);
    en = 1'b1;
    @(negedge clk_in);
    run_len(n);
    chk("restart_high2", 32'(n), 32'd2);
    run_len(n);
    chk("restart_low2", 32'(n), 32'd2);
    en = 1'b0;
    wait_idle("restart_stop");

    // zero half-period request
    send_cfg(8'd0);
`ifdef CLK_DIV_CTRL_CHK_EN
    chk("zero_err_pulse", 32'(cfg_err),   32'd1);
    chk("zero_ready",     32'(cfg_ready), 32'd1);
    @(negedge clk_in);
    chk("zero_err_clear", 32'(cfg_err),  32'd0);
    chk("zero_half_kept", 32'(cur_half), 32'd2);
`else
    chk("zero_ready_low", 32'(cfg_ready), 32'd0);
    @(negedge clk_in);
    chk("zero_clamped", 32'(cur_half), 32'd1);
    chk("zero_no_err",  32'(cfg_err),  32'd0);
`endif

    // async reset mid-low-phase with a pending config
    send_cfg(8'd3);
    @(negedge clk_in);
    en = 1'b1;
    wait_clk(1'b0, "arst_wait_low");
    send_cfg(8'd7);
    chk("arst_pending", 32'(cfg_ready), 32'd0);
    #2 arst_n = 1'b0;
    #1;
    chk("arst_clk",    32'(clk_out),   32'd0);
    chk("arst_half",   32'(cur_half),  32'd1);
    chk("arst_active", 32'(active),    32'd0);
    chk("arst_ready",  32'(cfg_ready), 32'd1);
    en = 1'b0;
    @(negedge clk_in);
    arst_n = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("post_rst_half",  32'(cur_half),  32'd1);
    chk("post_rst_ready", 32'(cfg_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
